// File: rtl/video_timing_gen_if.sv
// Video-side bundle of the raster timing generator: pixel enable, per-frame controls,
// core pixel in, and the registered timing/pixel outputs toward the video back end.
interface video_timing_gen_if #(
    parameter int unsigned CW = 12
) ();
    logic          PCE;
    logic [4:0]    HOFFS;
    logic [2:0]    VOFFS;
    logic          FLIP;
    logic [CW-1:0] iRGB;

    logic [9:0]    HPOS;
    logic [9:0]    VPOS;
    logic          HBLK;
    logic          VBLK;
    logic          HSYN;
    logic          VSYN;
    logic          LSTART;
    logic          FSTART;
    logic [CW-1:0] oRGB;
    logic          oDE;

    modport master (
        input  PCE, HOFFS, VOFFS, FLIP, iRGB,
        output HPOS, VPOS, HBLK, VBLK, HSYN, VSYN, LSTART, FSTART, oRGB, oDE
    );

    modport slave (
        output PCE, HOFFS, VOFFS, FLIP, iRGB,
        input  HPOS, VPOS, HBLK, VBLK, HSYN, VSYN, LSTART, FSTART, oRGB, oDE
    );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel coordinates, blanking, active-low syncs with
// per-frame offsets and flip, line/frame strobes and a blanked, registered RGB output.
module video_timing_gen #(
    parameter int unsigned CW      = 12,
    parameter int unsigned H_ACT   = 256,
    parameter int unsigned H_BEG   = 16,
    parameter int unsigned H_TOT   = 384,
    parameter int unsigned HS_BASE = 288,
    parameter int unsigned HS_LEN  = 32,
    parameter int unsigned V_ACT   = 224,
    parameter int unsigned V_TOT   = 262,
    parameter int unsigned VS_BASE = 226,
    parameter int unsigned VS_LEN  = 4
) (
    input logic                MCLK,
    input logic                RESET_N,
    video_timing_gen_if.master vid
);

    localparam logic [10:0] HTot   = 11'(H_TOT);
    localparam logic [10:0] HBeg   = 11'(H_BEG);
    localparam logic [10:0] HEnd   = 11'(H_BEG + H_ACT);
    localparam logic [10:0] HsBase = 11'(HS_BASE);
    localparam logic [10:0] HsLen  = 11'(HS_LEN);
    localparam logic [10:0] VTot   = 11'(V_TOT);
    localparam logic [10:0] VAct   = 11'(V_ACT);
    localparam logic [10:0] VsBase = 11'(VS_BASE);
    localparam logic [10:0] VsLen  = 11'(VS_LEN);
    localparam logic [9:0]  HLast  = 10'(H_TOT - 1);
    localparam logic [9:0]  VLast  = 10'(V_TOT - 1);
    localparam logic [9:0]  HBeg10 = 10'(H_BEG);
    localparam logic [9:0]  HActM1 = 10'(H_ACT - 1);
    localparam logic [9:0]  VActM1 = 10'(V_ACT - 1);

    // Raster counters: the position that the next PCE will present on the outputs.
    logic [9:0]    hcnt_q, hcnt_d;
    logic [9:0]    vcnt_q, vcnt_d;

    logic [4:0]    hoff_s_q;
    logic [2:0]    voff_s_q;
    logic          flip_s_q;

    logic [9:0]    hpos_q, hpos_d;
    logic [9:0]    vpos_q, vpos_d;
    logic          hblk_q, hblk_d;
    logic          vblk_q, vblk_d;
    logic          hsyn_q, hsyn_d;
    logic          vsyn_q, vsyn_d;
    logic          lstart_q, lstart_d;
    logic          fstart_q, fstart_d;
    logic [CW-1:0] orgb_q, orgb_d;
    logic          ode_q, ode_d;

    logic          frame_start;
    logic [4:0]    hoff_e;
    logic [2:0]    voff_e;
    logic          flip_e;
    logic [10:0]   hs_sum, hs_b;
    logic [10:0]   vs_sum, vs_b;
    logic [10:0]   h_ext, v_ext;
    logic [10:0]   h_rel, v_rel;
    logic          hs_on, vs_on;
    logic [9:0]    x_raw;

    // At (0,0) the shadows are being loaded, so the new frame already uses the fresh inputs.
    always_comb begin
        frame_start = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
        hoff_e      = frame_start ? vid.HOFFS : hoff_s_q;
        voff_e      = frame_start ? vid.VOFFS : voff_s_q;
        flip_e      = frame_start ? vid.FLIP  : flip_s_q;
    end

    always_comb begin
        hs_sum = HsBase + {5'd0, hoff_e, 1'b0};
        hs_b   = (hs_sum >= HTot) ? hs_sum - HTot : hs_sum;
        vs_sum = VsBase + {6'd0, voff_e, 2'b00};
        vs_b   = (vs_sum >= VTot) ? vs_sum - VTot : vs_sum;
        h_ext  = {1'b0, hcnt_q};
        v_ext  = {1'b0, vcnt_q};
        // Distance past the sync start, modulo the total, so windows wrap through 0.
        h_rel  = (h_ext >= hs_b) ? h_ext - hs_b : h_ext + HTot - hs_b;
        v_rel  = (v_ext >= vs_b) ? v_ext - vs_b : v_ext + VTot - vs_b;
        hs_on  = h_rel < HsLen;
        vs_on  = v_rel < VsLen;
    end

    always_comb begin
        hblk_d   = !((h_ext >= HBeg) && (h_ext < HEnd));
        vblk_d   = !(v_ext < VAct);
        x_raw    = hcnt_q - HBeg10;
        hsyn_d   = !hs_on;
        // Vertical sync only moves at the horizontal sync start of each line.
        vsyn_d   = (h_ext == hs_b) ? !vs_on : vsyn_q;
        lstart_d = (hcnt_q == 10'd0);
        fstart_d = frame_start;
        if (flip_e && !hblk_d && !vblk_d) begin
            hpos_d = HActM1 - x_raw;
            vpos_d = VActM1 - vcnt_q;
        end else begin
            hpos_d = x_raw;
            vpos_d = vcnt_q;
        end
    end

    // The pixel stage follows the registered position, giving one PCE of iRGB latency.
    always_comb begin
        ode_d  = !(hblk_q || vblk_q);
        orgb_d = ode_d ? vid.iRGB : '0;
    end

    always_comb begin
        if (hcnt_q == HLast) begin
            hcnt_d = 10'd0;
            vcnt_d = (vcnt_q == VLast) ? 10'd0 : vcnt_q + 10'd1;
        end else begin
            hcnt_d = hcnt_q + 10'd1;
            vcnt_d = vcnt_q;
        end
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            hoff_s_q <= '0;
            voff_s_q <= '0;
            flip_s_q <= 1'b0;
            hpos_q   <= '0;
            vpos_q   <= '0;
            hblk_q   <= 1'b1;
            vblk_q   <= 1'b1;
            hsyn_q   <= 1'b1;
            vsyn_q   <= 1'b1;
            lstart_q <= 1'b0;
            fstart_q <= 1'b0;
            orgb_q   <= '0;
            ode_q    <= 1'b0;
        end else if (vid.PCE) begin
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            if (frame_start) begin
                hoff_s_q <= vid.HOFFS;
                voff_s_q <= vid.VOFFS;
                flip_s_q <= vid.FLIP;
            end
            hpos_q   <= hpos_d;
            vpos_q   <= vpos_d;
            hblk_q   <= hblk_d;
            vblk_q   <= vblk_d;
            hsyn_q   <= hsyn_d;
            vsyn_q   <= vsyn_d;
            lstart_q <= lstart_d;
            fstart_q <= fstart_d;
            orgb_q   <= orgb_d;
            ode_q    <= ode_d;
        end
    end

    assign vid.HPOS   = hpos_q;
    assign vid.VPOS   = vpos_q;
    assign vid.HBLK   = hblk_q;
    assign vid.VBLK   = vblk_q;
    assign vid.HSYN   = hsyn_q;
    assign vid.VSYN   = vsyn_q;
    assign vid.LSTART = lstart_q;
    assign vid.FSTART = fstart_q;
    assign vid.oRGB   = orgb_q;
    assign vid.oDE    = ode_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench: a reduced-raster instance checked every MCLK against a frame-position model, plus a
// default-parameter instance pinned with hand-computed values at key pixels.
module tb_video_timing_gen;

    localparam int HT  = 64;
    localparam int HB  = 8;
    localparam int HA  = 40;
    localparam int HSB = 52;
    localparam int HL  = 6;
    localparam int VT  = 32;
    localparam int VA  = 24;
    localparam int VSB = 26;
    localparam int VL  = 3;

    logic clk     = 1'b0;
    logic rst1_n  = 1'b1;
    logic rst2_n  = 1'b1;
    logic cmp_on  = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cnt2     = 0;

    always #5 clk = ~clk;

    video_timing_gen_if #(.CW(12)) v1 ();
    video_timing_gen_if #(.CW(12)) v2 ();

    // Core pixel: a pattern derived from the coordinates it is asked for.
    assign v1.iRGB = {v1.HPOS[5:0], v1.VPOS[5:0]};
    assign v2.iRGB = {v2.HPOS[5:0], v2.VPOS[5:0]};

    video_timing_gen #(
        .CW(12), .H_ACT(HA), .H_BEG(HB), .H_TOT(HT), .HS_BASE(HSB), .HS_LEN(HL),
        .V_ACT(VA), .V_TOT(VT), .VS_BASE(VSB), .VS_LEN(VL)
    ) u_dut1 (
        .MCLK   (clk),
        .RESET_N(rst1_n),
        .vid    (v1)
    );

    video_timing_gen #(.CW(12)) u_dut2 (
        .MCLK   (clk),
        .RESET_N(rst2_n),
        .vid    (v2)
    );

    typedef struct {
        int n;
        bit valid;
        int ph, pv;
        int hoff, voff;
        bit flip;
        bit hblk, vblk, hsyn, vsyn, ls, fs, de;
        int hpos, vpos, rgb;
    } mst_t;

    mst_t m;

    function automatic mst_t reset_st();
        mst_t r;
        r = '{n: 0, valid: 0, ph: 0, pv: 0, hoff: 0, voff: 0, flip: 0, hblk: 1, vblk: 1,
              hsyn: 1, vsyn: 1, ls: 0, fs: 0, de: 0, hpos: 0, vpos: 0, rgb: 0};
        return r;
    endfunction

    // One pixel step: n is the linear index of the pixel being presented within the frame.
    function automatic mst_t step(mst_t s, int hoffs, int voffs, bit flip);
        mst_t r = s;
        int h, v, hsb, vsb, x;
        bit act;
        h = s.n % HT;
        v = s.n / HT;
        if (h == 0 && v == 0) begin
            r.hoff = hoffs;
            r.voff = voffs;
            r.flip = flip;
        end
        hsb    = (HSB + 2 * r.hoff) % HT;
        vsb    = (VSB + 4 * r.voff) % VT;
        r.de   = !(s.hblk || s.vblk);
        r.rgb  = r.de ? ((s.hpos % 64) * 64 + (s.vpos % 64)) : 0;
        r.hblk = !(h >= HB && h < HB + HA);
        r.vblk = !(v < VA);
        act    = !r.hblk && !r.vblk;
        x      = (h - HB + 1024) % 1024;
        r.hpos = (r.flip && act) ? HA - 1 - x : x;
        r.vpos = (r.flip && act) ? VA - 1 - v : v;
        r.hsyn = ((h - hsb + HT) % HT) >= HL;
        if (h == hsb) r.vsyn = ((v - vsb + VT) % VT) >= VL;
        r.ls    = (h == 0);
        r.fs    = (h == 0 && v == 0);
        r.ph    = h;
        r.pv    = v;
        r.valid = 1'b1;
        r.n     = (s.n + 1) % (HT * VT);
        return r;
    endfunction

    always @(posedge clk or negedge rst1_n) begin
        if (!rst1_n) m <= reset_st();
        else if (v1.PCE) m <= step(m, int'(v1.HOFFS), int'(v1.VOFFS), v1.FLIP);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("m_hblk", 32'(v1.HBLK), 32'(m.hblk));
            check("m_vblk", 32'(v1.VBLK), 32'(m.vblk));
            check("m_hsyn", 32'(v1.HSYN), 32'(m.hsyn));
            check("m_vsyn", 32'(v1.VSYN), 32'(m.vsyn));
            check("m_lstart", 32'(v1.LSTART), 32'(m.ls));
            check("m_fstart", 32'(v1.FSTART), 32'(m.fs));
            check("m_ode", 32'(v1.oDE), 32'(m.de));
            check("m_orgb", 32'(v1.oRGB), 32'(m.rgb));
            if (m.valid) begin
                check("m_hpos", 32'(v1.HPOS), 32'(m.hpos));
                check("m_vpos", 32'(v1.VPOS), 32'(m.vpos));
            end
        end
    end

    // All stimulus runs at posedge+1; one PCE then gap idle MCLKs.
    task automatic pulse(input int gap);
        v1.PCE = 1'b1;
        @(posedge clk); #1;
        v1.PCE = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic goto(input int h, input int v, input int gap);
        int n = 0;
        while (!(m.valid && m.ph == h && m.pv == v) && n < 5000) begin
            pulse(gap);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            failures++;
            $display("FAIL goto_timeout: got no pixel %0d,%0d, want it within 5000 PCEs", h, v);
        end
    endtask

    task automatic goto2(input int h);
        while (cnt2 < h + 1) begin
            v2.PCE = 1'b1;
            @(posedge clk); #1;
            v2.PCE = 1'b0;
            cnt2++;
        end
    endtask

    initial begin
        v1.PCE = 1'b0; v1.HOFFS = 5'd0; v1.VOFFS = 3'd0; v1.FLIP = 1'b0;
        v2.PCE = 1'b0; v2.HOFFS = 5'd31; v2.VOFFS = 3'd0; v2.FLIP = 1'b1;
        #1;
        rst1_n = 1'b0;
        rst2_n = 1'b0;
        @(posedge clk); #1;
        cmp_on = 1'b1;

        check("rst_hblk", 32'(v1.HBLK), 1);
        check("rst_vblk", 32'(v1.VBLK), 1);
        check("rst_hsyn", 32'(v1.HSYN), 1);
        check("rst_vsyn", 32'(v1.VSYN), 1);
        check("rst_fstart", 32'(v1.FSTART), 0);
        check("rst_ode", 32'(v1.oDE), 0);
        check("rst_orgb", 32'(v1.oRGB), 0);

        // Default-parameter instance: HOFFS=31, FLIP=1 from the first frame.
        rst2_n = 1'b1;
        @(posedge clk); #1;
        goto2(0);
        check("d_fstart", 32'(v2.FSTART), 1);
        check("d_hpos0", 32'(v2.HPOS), 1008);
        check("d_hblk0", 32'(v2.HBLK), 1);
        check("d_vblk0", 32'(v2.VBLK), 0);
        goto2(15);
        check("d_hblk15", 32'(v2.HBLK), 1);
        goto2(16);
        check("d_hblk16", 32'(v2.HBLK), 0);
        check("d_hpos16", 32'(v2.HPOS), 255);
        check("d_vpos16", 32'(v2.VPOS), 223);
        goto2(17);
        check("d_orgb17", 32'(v2.oRGB), 4063);
        check("d_ode17", 32'(v2.oDE), 1);
        check("d_hpos17", 32'(v2.HPOS), 254);
        goto2(271);
        check("d_hpos271", 32'(v2.HPOS), 0);
        check("d_hblk271", 32'(v2.HBLK), 0);
        goto2(272);
        check("d_hblk272", 32'(v2.HBLK), 1);
        check("d_hpos272", 32'(v2.HPOS), 256);
        goto2(273);
        check("d_ode273", 32'(v2.oDE), 0);
        check("d_orgb273", 32'(v2.oRGB), 0);
        goto2(349);
        check("d_hsyn349", 32'(v2.HSYN), 1);
        goto2(350);
        check("d_hsyn350", 32'(v2.HSYN), 0);
        goto2(381);
        check("d_hsyn381", 32'(v2.HSYN), 0);
        goto2(382);
        check("d_hsyn382", 32'(v2.HSYN), 1);
        rst2_n = 1'b0;

        // Reduced-raster instance, frame 1: offsets 0, no flip.
        rst1_n = 1'b1;
        @(posedge clk); #1;
        pulse(0);
        check("f1_fstart", 32'(v1.FSTART), 1);
        check("f1_lstart", 32'(v1.LSTART), 1);
        check("f1_hpos0", 32'(v1.HPOS), 1016);
        check("f1_vpos0", 32'(v1.VPOS), 0);
        goto(8, 0, 0);
        check("f1_hblk8", 32'(v1.HBLK), 0);
        check("f1_hpos8", 32'(v1.HPOS), 0);
        goto(47, 0, 0);
        check("f1_hpos47", 32'(v1.HPOS), 39);
        goto(48, 0, 0);
        check("f1_hblk48", 32'(v1.HBLK), 1);
        goto(52, 0, 0);
        check("f1_hsyn52", 32'(v1.HSYN), 0);
        goto(57, 0, 0);
        check("f1_hsyn57", 32'(v1.HSYN), 0);
        goto(58, 0, 0);
        check("f1_hsyn58", 32'(v1.HSYN), 1);
        goto(0, 10, 3);
        v1.VOFFS = 3'd7;
        v1.HOFFS = 5'd31;
        goto(63, 23, 3);
        check("f1_vblk23", 32'(v1.VBLK), 0);
        goto(0, 24, 3);
        check("f1_vblk24", 32'(v1.VBLK), 1);
        goto(51, 26, 3);
        check("f1_vsyn_pre", 32'(v1.VSYN), 1);
        goto(52, 26, 3);
        check("f1_vsyn26", 32'(v1.VSYN), 0);
        goto(52, 28, 3);
        check("f1_vsyn28", 32'(v1.VSYN), 0);
        goto(52, 29, 3);
        check("f1_vsyn29", 32'(v1.VSYN), 1);

        // Frame 2: hs_b = 50, vs_b = 22.
        goto(0, 0, 0);
        check("f2_fstart", 32'(v1.FSTART), 1);
        goto(49, 0, 0);
        check("f2_hsyn49", 32'(v1.HSYN), 1);
        goto(50, 0, 0);
        check("f2_hsyn50", 32'(v1.HSYN), 0);
        goto(55, 0, 0);
        check("f2_hsyn55", 32'(v1.HSYN), 0);
        goto(56, 0, 0);
        check("f2_hsyn56", 32'(v1.HSYN), 1);
        goto(0, 10, 0);
        v1.HOFFS = 5'd4;
        v1.VOFFS = 3'd1;
        v1.FLIP  = 1'b1;
        goto(49, 22, 0);
        check("f2_vsyn_pre", 32'(v1.VSYN), 1);
        goto(50, 22, 0);
        check("f2_vsyn22", 32'(v1.VSYN), 0);
        goto(50, 24, 0);
        check("f2_vsyn24", 32'(v1.VSYN), 0);
        goto(50, 25, 0);
        check("f2_vsyn25", 32'(v1.VSYN), 1);

        // Frame 3: hs_b = 60 (wraps to hcnt 1), vs_b = 30 (wraps to line 0), flipped.
        goto(0, 0, 0);
        check("f3_hsyn0", 32'(v1.HSYN), 0);
        goto(1, 0, 0);
        check("f3_hsyn1", 32'(v1.HSYN), 0);
        goto(2, 0, 0);
        check("f3_hsyn2", 32'(v1.HSYN), 1);
        goto(8, 0, 0);
        check("f3_hpos8", 32'(v1.HPOS), 39);
        check("f3_vpos8", 32'(v1.VPOS), 23);
        goto(9, 0, 0);
        check("f3_orgb9", 32'(v1.oRGB), 2519);
        check("f3_ode9", 32'(v1.oDE), 1);
        goto(59, 0, 0);
        check("f3_hsyn59", 32'(v1.HSYN), 1);
        goto(60, 0, 0);
        check("f3_hsyn60", 32'(v1.HSYN), 0);
        check("f3_vsyn0", 32'(v1.VSYN), 0);
        goto(60, 1, 0);
        check("f3_vsyn1", 32'(v1.VSYN), 1);
        goto(59, 30, 0);
        check("f3_vsyn30_pre", 32'(v1.VSYN), 1);
        goto(60, 30, 0);
        check("f3_vsyn30", 32'(v1.VSYN), 0);

        // Mid-frame asynchronous reset.
        goto(20, 15, 0);
        check("pre_rst_ode", 32'(v1.oDE), 1);
        rst1_n = 1'b0;
        #1;
        check("mrst_hblk", 32'(v1.HBLK), 1);
        check("mrst_vblk", 32'(v1.VBLK), 1);
        check("mrst_hsyn", 32'(v1.HSYN), 1);
        check("mrst_vsyn", 32'(v1.VSYN), 1);
        check("mrst_lstart", 32'(v1.LSTART), 0);
        check("mrst_ode", 32'(v1.oDE), 0);
        check("mrst_orgb", 32'(v1.oRGB), 0);
        @(posedge clk); #1;
        rst1_n = 1'b1;
        @(posedge clk); #1;
        pulse(0);
        check("arst_fstart", 32'(v1.FSTART), 1);
        check("arst_hpos", 32'(v1.HPOS), 1016);
        check("arst_vpos", 32'(v1.VPOS), 0);

        // PCE held low mid-line.
        goto(30, 5, 0);
        check("hold_hpos_a", 32'(v1.HPOS), 17);
        check("hold_vpos_a", 32'(v1.VPOS), 18);
        repeat (1000) begin
            @(posedge clk); #1;
        end
        check("hold_hpos_b", 32'(v1.HPOS), 17);
        check("hold_vpos_b", 32'(v1.VPOS), 18);
        check("hold_hblk_b", 32'(v1.HBLK), 0);
        pulse(0);
        check("resume_hpos", 32'(v1.HPOS), 16);
        check("resume_orgb", 32'(v1.oRGB), 1106);

        @(posedge clk); #1;
        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no end of stimulus, want it before %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the arcade cores, replacing the fixed 256×224 generator. It runs on the core master clock with a pixel clock-enable and produces pixel coordinates, blanking, active-low syncs, line/frame strobes and a blanked, registered RGB output. It also adds per-frame latched sync offsets and screen flip. It sits between the game core's video pipeline and `arcade_video`.

## Interface
- `CW`, 12, RGB bus width
- `H_ACT`, 256, active pixels per line
- `H_BEG`, 16, hcnt value of first active pixel
- `H_TOT`, 384, total pixels per line (≤ 1024)
- `HS_BASE`, 288, hcnt of HSYNC start with offset 0
- `HS_LEN`, 32, HSYNC width in pixels
- `V_ACT`, 224, active lines
- `V_TOT`, 262, total lines per frame (≤ 1024)
- `VS_BASE`, 226, vcnt of VSYNC start with offset 0
- `VS_LEN`, 4, VSYNC width in lines
- `MCLK`  in  1  master clock
- `RESET_N`  in  1  asynchronous active-low reset
- `PCE`  in  1  pixel clock-enable; all state advances only when 1
- `HOFFS`  in  5  HSYNC offset; step 2 pixels
- `VOFFS`  in  3  VSYNC offset; step 4 lines
- `FLIP`  in  1  mirror both HPOS and VPOS
- `iRGB`  in  CW  pixel from core for current HPOS/VPOS
- `HPOS`  out  10  horizontal coordinate (hcnt−H_BEG, mod 1024; mirrored when flipped)
- `VPOS`  out  10  vertical coordinate (vcnt; mirrored when flipped)
- `HBLK`, `VBLK`  out  1  blanking, aligned with HPOS/VPOS
- `HSYN`, `VSYN`  out  1  syncs, active low
- `LSTART`, `FSTART`  out  1  one-PCE strobes at hcnt==0 and at hcnt==0&&vcnt==0
- `oRGB`  out  CW  registered pixel, 0 when blanked
- `oDE`  out  1  data enable aligned with oRGB

## Operation
- hcnt counts 0..H_TOT−1. At H_TOT−1 it wraps to 0 and vcnt increments. vcnt counts 0..V_TOT−1 and wraps to 0.
- Shadow offset/flip registers (`hoff_s`, `voff_s`, `flip_s`) load HOFFS, VOFFS and FLIP on the PCE where the counters wrap to (0,0). Mid-frame input changes have no effect until the next frame.
- Sync position and width:
  - hs_b = (HS_BASE + 2·hoff_s) mod H_TOT; HSYN = 0 for HS_LEN pixels starting at hs_b. The window wraps through hcnt 0 when hs_b+HS_LEN > H_TOT.
  - vs_b = (VS_BASE + 4·voff_s) mod V_TOT; VSYN = 0 for VS_LEN lines starting at vs_b, with the same wrap rule.
  - VSYN edges change only on the hcnt==hs_b PCE, so they are line-synchronous.
- Blanking: HBLK = 0 iff H_BEG ≤ hcnt < H_BEG+H_ACT; VBLK = 0 iff vcnt < V_ACT.
- Flip: when flip_s=1 and the position is active, HPOS = H_ACT−1−x and VPOS = V_ACT−1−y. During blanking, HPOS/VPOS are the unmirrored values.
- Output stage: oRGB = (HBLK|VBLK) ? 0 : iRGB and oDE = ~(HBLK|VBLK), both registered from the current position.
- Arithmetic: the offset sums are computed at 11 bits, then reduced modulo the total with a single conditional subtract. Parameters guarantee HS_BASE < H_TOT and VS_BASE < V_TOT.

## Timing
- Reset (RESET_N low, async) values:
  - hcnt = vcnt = 0; shadow registers = 0.
  - HBLK = VBLK = 1; HSYN = VSYN = 1; LSTART = FSTART = 0; oRGB = 0; oDE = 0.
- The first PCE after reset release loads the shadow registers and raises FSTART/LSTART together with position (0,0).
- HPOS, VPOS, HBLK, VBLK, HSYN, VSYN, LSTART and FSTART are registered, all updated on the same PCE, and mutually aligned.
- oRGB/oDE are registered one PCE later than the position that selected them. Latency iRGB→oRGB is 1 PCE.
- With PCE=0, every output holds.
- Last pixel of the frame (H_TOT−1, V_TOT−1): the next PCE produces the hcnt/vcnt wrap, the shadow load and FSTART in a single cycle.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously); no partial sync pulse is extended.

## Test plan
- Defaults, PCE every 4th MCLK, HOFFS=VOFFS=0 → HBLK low for exactly 256 PCEs per line starting hcnt=16; HSYN low hcnt 288..319; VSYN low lines 226..229; FSTART period 384·262 PCEs.
- HOFFS=31 → hs_b=(288+62) mod 384=350; HSYN low 350..381. HS_LEN raised to 40 → pulse wraps, low 350..383 and 0..5.
- VOFFS changed from 0 to 7 at line 100 → current frame keeps VSYN at 226; next frame VSYN low lines 254..257.
- FLIP=1, iRGB = {HPOS,VPOS} pattern → first active pixel reports HPOS=255, VPOS=223; oRGB appears 1 PCE later; oRGB=0 and oDE=0 on every blanked pixel.
- RESET_N pulsed low at hcnt=200, vcnt=150 → outputs immediately at reset values; after release, next PCE shows (0,0) with FSTART=1.
- PCE held low for 1000 MCLK mid-line → all outputs unchanged; timing resumes exactly at the held position.
